signext_pipe: RTL

- Parametrised, pipelined successor to the fixed 2→8 sign extender.
- Widens LANES packed lanes of IN_W bits to OUT_W bits each.
- Fill mode is selectable per transfer: zero, sign, or ones.
- Sits between the datapath producers (e.g. the 2-bit input decode) and the 8-bit-or-wider arithmetic/display consumers.
- Valid/ready handshake with a 2-entry skid buffer, so it can be dropped into a stalled pipeline without combinational ready paths.

---
 rtl/signext_pipe_pkg.sv | 21 ++
 rtl/signext_lane.sv | 20 ++
 rtl/signext_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/signext_pipe_pkg.sv
// Shared definitions for the pipelined sign/zero/ones extender.
package signext_pipe_pkg;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_SIGN = 2'b01;
  localparam logic [1:0] MODE_ONES = 2'b10;

  localparam int COUNT_W = 16;

  // Fill bit for the upper part of a lane; the unused 2'b11 encoding behaves as sign.
  function automatic logic fill_bit(input logic [1:0] mode, input logic msb);
    logic fb;
    case (mode)
      MODE_ZERO: fb = 1'b0;
      MODE_ONES: fb = 1'b1;
      default:   fb = msb;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/signext_lane.sv
// One lane of the extender: IN_W bits widened to OUT_W bits with the selected fill.
module signext_lane #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  lane_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] lane_out
);
  import signext_pipe_pkg::*;

  logic [OUT_W-1:0] fill_vec;

  // Fill pattern shifted above the input bits; when OUT_W==IN_W the shift clears it entirely.
  always_comb begin
    fill_vec = {OUT_W{fill_bit(mode, lane_in[IN_W-1])}};
    lane_out = (fill_vec << IN_W) | OUT_W'(lane_in);
  end

endmodule

// File: rtl/signext_pipe.sv
// Pipelined multi-lane extender with a valid/ready interface and a 2-entry skid buffer.
// Lanes are extended on the way in, so the fill mode travels with the stored data.
module signext_pipe
  import signext_pipe_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   Clear_n,
  input  logic                   Clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [COUNT_W-1:0]     out_count
);

  logic [LANES*OUT_W-1:0] ext_data;
  logic [LANES*OUT_W-1:0] out_data_q;
  logic [LANES*OUT_W-1:0] skid_data_q;
  logic                   out_valid_q;
  logic                   skid_valid_q;
  logic [COUNT_W-1:0]     count_q;
  logic                   in_xfer;
  logic                   out_xfer;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    signext_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .lane_in  (in_data[k*IN_W +: IN_W]),
      .mode     (in_mode),
      .lane_out (ext_data[k*OUT_W +: OUT_W])
    );
  end

  // in_ready comes straight from a flop, so no combinational path from out_ready.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = count_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  // Output register and skid register; the skid entry always drains before new input.
  always_ff @(posedge clk) begin
    if (!Clear_n || Clear) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (!out_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_xfer) begin
        out_data_q  <= ext_data;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data_q  <= ext_data;
      skid_valid_q <= 1'b1;
    end
  end

  // Completed output transfers; a flush keeps the count, only Clear_n zeroes it.
  always_ff @(posedge clk) begin
    if (!Clear_n) begin
      count_q <= '0;
    end else if (Clear) begin
      count_q <= count_q;
    end else if (out_xfer) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
